bus_cycle_fsm: RTL and testbench
================================

BUS_CYCLE_FSM -- requirements
Module: bus_cycle_fsm

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning address bus width; legal values are 16 or more.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data bus width.
REQ-003 The block SHALL have parameter IO_WAIT, default 1, meaning automatic wait states inserted in I/O cycles; legal range is 0..3.
REQ-004 clk  in  1  Single clock; all state changes on its rising edge.
REQ-005 rst_L  in  1  Reset; asynchronous, active-low.
REQ-006 start  in  1  Request a machine cycle.
REQ-007 cyc_type  in  3  Cycle type: 0=OCF, 1=MEM_RD, 2=MEM_WR, 3=IO_RD, 4=IO_WR; 5..7 reserved.
REQ-008 addr_in  in  ADDR_W  Cycle address, sampled with start.
REQ-009 wdata_in  in  DATA_W  Write data, sampled with start.
REQ-010 data_in  in  DATA_W  External data bus.
REQ-011 ireg_in  in  8  I register, used as the refresh address high byte.
REQ-012 WAIT_L  in  1  External wait request, active-low.
REQ-013 addr_out  out  ADDR_W  Address bus.
REQ-014 data_out and data_oe  out  DATA_W and 1  Write data and its drive enable.
REQ-015 M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  Bus strobes, active-low.
REQ-016 busy, done  out  1 each  busy: cycle in progress; done: one-cycle pulse in the final T-state.
REQ-017 rdata_out and rdata_valid  out  DATA_W and 1  Captured read data, plus a one-cycle valid pulse.

Function
REQ-018 The state machine SHALL have states IDLE, T1, T2, TA (automatic wait), TW (external wait), T3 and T4.
REQ-019 In IDLE, or in the final T-state, a start with a legal cyc_type SHALL latch cyc_type, addr_in and wdata_in, and the next state SHALL be T1; start-to-T1 latency is 1 clock, and back-to-back cycles have no idle gap.
REQ-020 A start in any other state, or with a reserved cyc_type, SHALL be ignored, with no state change and no busy assertion.
REQ-021 Sequences: OCF = T1,T2,[TW*],T3,T4; MEM_RD and MEM_WR = T1,T2,[TW*],T3; IO_RD and IO_WR = T1,T2,TA×IO_WAIT,[TW*],T3.
REQ-022 WAIT_L SHALL be sampled on the clock edge that leaves T2 (memory cycles) or leaves the last TA (I/O cycles; this is T2 when IO_WAIT=0); if it is low, the FSM SHALL enter TW and stay there while WAIT_L=0, then go to T3.
REQ-023 OCF T1/T2/TW SHALL drive addr_out=latched address, M1_L=0, MREQ_L=0 and RD_L=0.
REQ-024 OCF read data SHALL be captured on the edge leaving T2 or TW into T3, with rdata_valid=1 during T3.
REQ-025 MEM_RD T1..T3 SHALL drive MREQ_L=0 and RD_L=0; data SHALL be captured on the edge leaving T3, with rdata_valid=1 on the following cycle.
REQ-026 MEM_WR SHALL drive data_oe=1 and data_out=latched wdata from T1 to T3, MREQ_L=0 from T1 to T3, and WR_L=0 in T2, TW and T3.
REQ-027 IO_RD and IO_WR SHALL drive IORQ_L=0 and RD_L=0 or WR_L=0 from T2 to T3 (including TA and TW).
REQ-028 IO_RD SHALL capture data as MEM_RD does, and IO_WR SHALL drive data as MEM_WR does.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 done SHALL be 1 only in T4 for OCF and only in T3 for all other cycle types.
REQ-031 In IDLE and outside the strobe windows, all strobes SHALL be 1, addr_out=0 and data_oe=0.

Reset
REQ-032 While rst_L=0, the FSM SHALL be in IDLE; all strobes SHALL be 1; addr_out, data_out, rdata_out and the R counter SHALL be 0; data_oe, busy, done and rdata_valid SHALL be 0.
REQ-033 Reset asserted mid-cycle (including in TW) SHALL abort the cycle immediately, with no done pulse and no rdata_valid pulse.

Configuration
REQ-034 With macro Z80_REFRESH_EN defined, OCF T3/T4 SHALL drive RFSH_L=0, MREQ_L=0, M1_L=1 and addr_out={zero-extend, ireg_in, R[7:0]}.
REQ-035 With Z80_REFRESH_EN defined, R[6:0] SHALL increment modulo 128 on the edge leaving OCF T4, with R[7] held at 0.
REQ-036 Without Z80_REFRESH_EN, there SHALL be no R counter, RFSH_L SHALL be tied to 1, and OCF T3/T4 SHALL drive MREQ_L=1 and addr_out=0; OCF timing is otherwise unchanged.

Structure
REQ-037 Package z80_bus_pkg SHALL hold the cyc_type_t enum, the tstate_t enum and the cycle-type encoding constants.
REQ-038 The R counter SHALL be the sub-module refresh_ctr, instantiated only under Z80_REFRESH_EN.

Verification
REQ-039 OCF test: addr 16'h1234, data_in 8'h3C, WAIT_L=1 -> T1..T4 in 4 clocks; M1_L low for 2 clocks; rdata_out=8'h3C in T3; done in T4.
REQ-040 MEM_RD test: WAIT_L low for 2 clocks at the end of T2 -> exactly 2 TW states; MEM_RD lasts 5 clocks; data captured after T3.
REQ-041 IO_WR test: IO_WAIT=1, wdata 8'hA5 -> T1,T2,TA,T3; IORQ_L and WR_L low for 3 clocks; data_out=8'hA5 with data_oe=1 for 4 clocks.
REQ-042 Back-to-back test: start held through OCF T4, then a MEM_WR -> T1 follows T4 directly; busy stays 1.
REQ-043 Refresh test (macro on): 130 OCFs with ireg_in=8'h40 -> R wraps 7F->00; refresh address 16'h4000 on the 129th OCF.
REQ-044 Reset test: rst_L pulled low in TW, plus a start with cyc_type=6 -> immediate IDLE with no done pulse; the reserved start is ignored and busy stays 0.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80-style bus cycle sequencer: cycle-type encoding,
// T-state enum and small cycle-classification helpers.
package z80_bus_pkg;

  localparam logic [2:0] CYC_OCF_C    = 3'd0;
  localparam logic [2:0] CYC_MEM_RD_C = 3'd1;
  localparam logic [2:0] CYC_MEM_WR_C = 3'd2;
  localparam logic [2:0] CYC_IO_RD_C  = 3'd3;
  localparam logic [2:0] CYC_IO_WR_C  = 3'd4;

  typedef enum logic [2:0] {
    CYC_OCF    = CYC_OCF_C,
    CYC_MEM_RD = CYC_MEM_RD_C,
    CYC_MEM_WR = CYC_MEM_WR_C,
    CYC_IO_RD  = CYC_IO_RD_C,
    CYC_IO_WR  = CYC_IO_WR_C
  } cyc_type_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TA   = 3'd3,
    TW   = 3'd4,
    T3   = 3'd5,
    T4   = 3'd6
  } tstate_t;

  // Encodings 5..7 are reserved and never start a cycle.
  function automatic logic cyc_legal(input logic [2:0] c);
    return (c <= CYC_IO_WR_C);
  endfunction

  function automatic logic cyc_is_io(input cyc_type_t c);
    return (c == CYC_IO_RD) || (c == CYC_IO_WR);
  endfunction

  function automatic logic cyc_is_data_read(input cyc_type_t c);
    return (c == CYC_MEM_RD) || (c == CYC_IO_RD);
  endfunction

endpackage

// File: rtl/bus_cycle_fsm_if.sv
// External bus bundle of bus_cycle_fsm: address/data buses, strobes and WAIT_L.
interface bus_cycle_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic              M1_L;
  logic              MREQ_L;
  logic              IORQ_L;
  logic              RD_L;
  logic              WR_L;
  logic              RFSH_L;
  logic              WAIT_L;

  modport master (
    output addr_out, data_out, data_oe,
    output M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L,
    input  data_in, WAIT_L
  );

  modport slave (
    input  addr_out, data_out, data_oe,
    input  M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L,
    output data_in, WAIT_L
  );

endinterface

// File: rtl/bus_cycle_fsm_refresh_ctr.sv
// 7-bit memory refresh counter (R register); bit 7 always reads as 0.
module refresh_ctr (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       inc,
  output logic [7:0] r_out
);

  logic [6:0] r_q;
  logic [6:0] r_d;

  always_comb begin
    r_d = r_q;
    if (inc) begin
      r_d = r_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign r_out = {1'b0, r_q};

endmodule

// File: rtl/bus_cycle_fsm.sv
// Z80-style machine-cycle sequencer (OCF, MEM_RD/WR, IO_RD/WR) with wait states.
// Optional refresh addressing in OCF T3/T4 is enabled by defining Z80_REFRESH_EN.
module bus_cycle_fsm
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int IO_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start,
  input  logic [2:0]        cyc_type,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [7:0]        ireg_in,
  bus_cycle_fsm_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid
);

  localparam logic [1:0] TA_LAST = 2'(IO_WAIT);

  tstate_t           state_q, state_d;
  cyc_type_t         cyc_q, cyc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ta_cnt_q, ta_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              final_st;
  logic              accept;
  logic              in_win;

  logic              m1_l, mreq_l, iorq_l, rd_l, wr_l, rfsh_l, oe;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;

`ifdef Z80_REFRESH_EN
  logic [7:0] r_val;

  refresh_ctr u_refresh_ctr (
    .clk   (clk),
    .rst_L (rst_L),
    .inc   (state_q == T4),
    .r_out (r_val)
  );
`else
  logic unused_ireg;
  assign unused_ireg = ^ireg_in;
`endif

  // The last T-state of a cycle can launch the next one with no idle gap.
  assign final_st = (state_q == T4) || ((state_q == T3) && (cyc_q != CYC_OCF));
  assign accept   = start && cyc_legal(cyc_type) && ((state_q == IDLE) || final_st);
  assign in_win   = state_q inside {T1, T2, TA, TW, T3};

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ta_cnt_d = ta_cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      T1:   state_d = T2;
      T2: begin
        if (cyc_is_io(cyc_q) && (IO_WAIT > 0)) begin
          state_d  = TA;
          ta_cnt_d = 2'd1;
        end else begin
          state_d = bus.WAIT_L ? T3 : TW;
        end
      end
      TA: begin
        if (ta_cnt_q == TA_LAST) begin
          state_d = bus.WAIT_L ? T3 : TW;
        end else begin
          ta_cnt_d = ta_cnt_q + 2'd1;
        end
      end
      TW:      state_d = bus.WAIT_L ? T3 : TW;
      T3:      state_d = (cyc_q == CYC_OCF) ? T4 : IDLE;
      T4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = T1;
      cyc_d   = cyc_type_t'(cyc_type);
      addr_d  = addr_in;
      wdata_d = wdata_in;
    end

    // Opcode fetch samples one state earlier than data reads.
    if ((cyc_q == CYC_OCF) && (state_q inside {T2, TW}) && (state_d == T3)) begin
      rdata_d  = bus.data_in;
      rvalid_d = 1'b1;
    end
    if (cyc_is_data_read(cyc_q) && (state_q == T3)) begin
      rdata_d  = bus.data_in;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q  <= IDLE;
      cyc_q    <= CYC_OCF;
      addr_q   <= '0;
      wdata_q  <= '0;
      ta_cnt_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ta_cnt_q <= ta_cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    m1_l   = 1'b1;
    mreq_l = 1'b1;
    iorq_l = 1'b1;
    rd_l   = 1'b1;
    wr_l   = 1'b1;
    rfsh_l = 1'b1;
    oe     = 1'b0;
    addr_o = '0;
    data_o = '0;

    case (cyc_q)
      CYC_OCF: begin
        if (state_q inside {T1, T2, TW}) begin
          addr_o = addr_q;
          m1_l   = 1'b0;
          mreq_l = 1'b0;
          rd_l   = 1'b0;
        end
`ifdef Z80_REFRESH_EN
        else if (state_q inside {T3, T4}) begin
          rfsh_l       = 1'b0;
          mreq_l       = 1'b0;
          addr_o[15:0] = {ireg_in, r_val};
        end
`endif
      end
      CYC_MEM_RD: begin
        if (in_win) begin
          addr_o = addr_q;
          mreq_l = 1'b0;
          rd_l   = 1'b0;
        end
      end
      CYC_MEM_WR: begin
        if (in_win) begin
          addr_o = addr_q;
          mreq_l = 1'b0;
          oe     = 1'b1;
          data_o = wdata_q;
          wr_l   = (state_q == T1);
        end
      end
      CYC_IO_RD: begin
        if (in_win && (state_q != T1)) begin
          addr_o = addr_q;
          iorq_l = 1'b0;
          rd_l   = 1'b0;
        end
      end
      CYC_IO_WR: begin
        if (in_win) begin
          oe     = 1'b1;
          data_o = wdata_q;
          if (state_q != T1) begin
            addr_o = addr_q;
            iorq_l = 1'b0;
            wr_l   = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.M1_L     = m1_l;
  assign bus.MREQ_L   = mreq_l;
  assign bus.IORQ_L   = iorq_l;
  assign bus.RD_L     = rd_l;
  assign bus.WR_L     = wr_l;
  assign bus.RFSH_L   = rfsh_l;
  assign bus.addr_out = addr_o;
  assign bus.data_out = data_o;
  assign bus.data_oe  = oe;

  assign busy        = (state_q != IDLE);
  assign done        = final_st;
  assign rdata_out   = rdata_q;
  assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_bus_cycle_fsm.sv
// Directed bench for bus_cycle_fsm: per-T-state strobe/address checks against
// hand-written vectors. Define Z80_REFRESH_EN to also exercise refresh addressing.
module tb_bus_cycle_fsm;
  import z80_bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  // {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, busy, done, data_oe}
  localparam logic [8:0] V_IDLE  = 9'b111111000;
  localparam logic [8:0] V_OCF_A = 9'b001011100;
`ifdef Z80_REFRESH_EN
  localparam logic [8:0] V_OCF_3 = 9'b101110100;
  localparam logic [8:0] V_OCF_4 = 9'b101110110;
`else
  localparam logic [8:0] V_OCF_3 = 9'b111111100;
  localparam logic [8:0] V_OCF_4 = 9'b111111110;
`endif
  localparam logic [8:0] V_MRD   = 9'b101011100;
  localparam logic [8:0] V_MRD_3 = 9'b101011110;
  localparam logic [8:0] V_MWR_1 = 9'b101111101;
  localparam logic [8:0] V_MWR   = 9'b101101101;
  localparam logic [8:0] V_MWR_3 = 9'b101101111;
  localparam logic [8:0] V_IOW_1 = 9'b111111101;
  localparam logic [8:0] V_IOW   = 9'b110101101;
  localparam logic [8:0] V_IOW_3 = 9'b110101111;
  localparam logic [8:0] V_IOR_1 = 9'b111111100;
  localparam logic [8:0] V_IOR   = 9'b110011100;
  localparam logic [8:0] V_IOR_3 = 9'b110011110;

  logic          clk = 1'b0;
  logic          rst_L = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    cyc_type = 3'd0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] wdata_in = '0;
  logic [7:0]    ireg_in = 8'h40;
  logic          busy;
  logic          done;
  logic [DW-1:0] rdata_out;
  logic          rdata_valid;

  int n_total = 0;
  int n_bad   = 0;
  int r_exp   = 0;

  bus_cycle_fsm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_cycle_fsm #(.ADDR_W(AW), .DATA_W(DW), .IO_WAIT(1)) dut (
    .clk         (clk),
    .rst_L       (rst_L),
    .start       (start),
    .cyc_type    (cyc_type),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .ireg_in     (ireg_in),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] snap();
    return {bus.M1_L, bus.MREQ_L, bus.IORQ_L, bus.RD_L, bus.WR_L, bus.RFSH_L,
            busy, done, bus.data_oe};
  endfunction

  function automatic logic [15:0] ref_addr(input int r);
`ifdef Z80_REFRESH_EN
    return {8'h40, 8'(r)};
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step(input string tag, input logic [8:0] exp_v,
                      input logic [AW-1:0] exp_a, input tstate_t exp_st);
    @(negedge clk);
    chk({tag, ".bus"}, 32'(snap()), 32'(exp_v));
    chk({tag, ".addr"}, 32'(bus.addr_out), 32'(exp_a));
    chk({tag, ".st"}, 32'(dut.state_q), 32'(exp_st));
  endtask

  initial begin
    bus.WAIT_L  = 1'b1;
    bus.data_in = '0;

    // Reset state
    step("rst0", V_IDLE, '0, IDLE);
    chk("rst0.rdata", 32'(rdata_out), 32'h0);
    chk("rst0.rvalid", 32'(rdata_valid), 32'h0);
    chk("rst0.dout", 32'(bus.data_out), 32'h0);
    rst_L = 1'b1;

    // Reserved cycle type in IDLE
    start = 1'b1; cyc_type = 3'd7;
    step("rsv", V_IDLE, '0, IDLE);
    step("rsv2", V_IDLE, '0, IDLE);
    start = 1'b0;
    $display("txn reserved cyc_type=7 ignored");

    // OCF, no wait
    start = 1'b1; cyc_type = CYC_OCF_C; addr_in = 16'h1234; bus.data_in = 8'h3C;
    step("ocf.t1", V_OCF_A, 16'h1234, T1);
    start = 1'b0;
    step("ocf.t2", V_OCF_A, 16'h1234, T2);
    step("ocf.t3", V_OCF_3, ref_addr(r_exp), T3);
    chk("ocf.rdata", 32'(rdata_out), 32'h3C);
    chk("ocf.rvalid3", 32'(rdata_valid), 32'h1);
    step("ocf.t4", V_OCF_4, ref_addr(r_exp), T4);
    chk("ocf.rvalid4", 32'(rdata_valid), 32'h0);
    r_exp = (r_exp + 1) % 128;
    step("ocf.end", V_IDLE, '0, IDLE);
    $display("txn OCF addr=1234 rdata=%02h", rdata_out);

    // MEM_RD with two external wait states
    start = 1'b1; cyc_type = CYC_MEM_RD_C; addr_in = 16'h0100; bus.data_in = 8'h11;
    step("mrd.t1", V_MRD, 16'h0100, T1);
    start = 1'b0;
    step("mrd.t2", V_MRD, 16'h0100, T2);
    bus.WAIT_L = 1'b0;
    step("mrd.tw1", V_MRD, 16'h0100, TW);
    step("mrd.tw2", V_MRD, 16'h0100, TW);
    bus.WAIT_L = 1'b1;
    step("mrd.t3", V_MRD_3, 16'h0100, T3);
    chk("mrd.rvalid3", 32'(rdata_valid), 32'h0);
    bus.data_in = 8'h5A;
    step("mrd.end", V_IDLE, '0, IDLE);
    chk("mrd.rvalid", 32'(rdata_valid), 32'h1);
    chk("mrd.rdata", 32'(rdata_out), 32'h5A);
    step("mrd.end2", V_IDLE, '0, IDLE);
    chk("mrd.rvalid_off", 32'(rdata_valid), 32'h0);
    $display("txn MEM_RD addr=0100 rdata=%02h", rdata_out);

    // IO_RD: automatic TA then one external wait after the last TA
    start = 1'b1; cyc_type = CYC_IO_RD_C; addr_in = 16'h0081; bus.data_in = 8'h00;
    step("ior.t1", V_IOR_1, '0, T1);
    start = 1'b0;
    step("ior.t2", V_IOR, 16'h0081, T2);
    step("ior.ta", V_IOR, 16'h0081, TA);
    bus.WAIT_L = 1'b0;
    step("ior.tw", V_IOR, 16'h0081, TW);
    bus.WAIT_L = 1'b1;
    step("ior.t3", V_IOR_3, 16'h0081, T3);
    bus.data_in = 8'hC3;
    step("ior.end", V_IDLE, '0, IDLE);
    chk("ior.rvalid", 32'(rdata_valid), 32'h1);
    chk("ior.rdata", 32'(rdata_out), 32'hC3);
    $display("txn IO_RD addr=0081 rdata=%02h", rdata_out);

    // IO_WR with IO_WAIT=1
    start = 1'b1; cyc_type = CYC_IO_WR_C; addr_in = 16'h0042; wdata_in = 8'hA5;
    step("iow.t1", V_IOW_1, '0, T1);
    chk("iow.dout1", 32'(bus.data_out), 32'hA5);
    start = 1'b0; wdata_in = 8'h00;
    step("iow.t2", V_IOW, 16'h0042, T2);
    chk("iow.dout2", 32'(bus.data_out), 32'hA5);
    step("iow.ta", V_IOW, 16'h0042, TA);
    chk("iow.doutA", 32'(bus.data_out), 32'hA5);
    step("iow.t3", V_IOW_3, 16'h0042, T3);
    chk("iow.dout3", 32'(bus.data_out), 32'hA5);
    step("iow.end", V_IDLE, '0, IDLE);
    chk("iow.dout_off", 32'(bus.data_out), 32'h0);
    $display("txn IO_WR addr=0042 wdata=a5");

    // Back-to-back: OCF with start held, then MEM_WR launched from T4
    start = 1'b1; cyc_type = CYC_OCF_C; addr_in = 16'h0ABC; bus.data_in = 8'h99;
    step("b2b.t1", V_OCF_A, 16'h0ABC, T1);
    step("b2b.t2", V_OCF_A, 16'h0ABC, T2);
    step("b2b.t3", V_OCF_3, ref_addr(r_exp), T3);
    step("b2b.t4", V_OCF_4, ref_addr(r_exp), T4);
    r_exp = (r_exp + 1) % 128;
    cyc_type = CYC_MEM_WR_C; addr_in = 16'h2000; wdata_in = 8'h77;
    step("b2b.w1", V_MWR_1, 16'h2000, T1);
    chk("b2b.dout", 32'(bus.data_out), 32'h77);
    start = 1'b0;
    step("b2b.w2", V_MWR, 16'h2000, T2);
    step("b2b.w3", V_MWR_3, 16'h2000, T3);
    step("b2b.end", V_IDLE, '0, IDLE);
    $display("txn OCF->MEM_WR back-to-back addr=2000 wdata=77");

    // Reset while stuck in TW, with a reserved start pending
    start = 1'b1; cyc_type = CYC_MEM_RD_C; addr_in = 16'h0300;
    step("rtw.t1", V_MRD, 16'h0300, T1);
    start = 1'b0;
    step("rtw.t2", V_MRD, 16'h0300, T2);
    bus.WAIT_L = 1'b0;
    step("rtw.tw", V_MRD, 16'h0300, TW);
    rst_L = 1'b0; start = 1'b1; cyc_type = 3'd6;
    #1;
    chk("rtw.bus", 32'(snap()), 32'(V_IDLE));
    chk("rtw.st", 32'(dut.state_q), 32'(IDLE));
    chk("rtw.addr", 32'(bus.addr_out), 32'h0);
    step("rtw.hold", V_IDLE, '0, IDLE);
    chk("rtw.rvalid", 32'(rdata_valid), 32'h0);
    chk("rtw.rdata", 32'(rdata_out), 32'h0);
    rst_L = 1'b1; bus.WAIT_L = 1'b1;
    r_exp = 0;
    step("rtw.rsv1", V_IDLE, '0, IDLE);
    step("rtw.rsv2", V_IDLE, '0, IDLE);
    chk("rtw.rvalid2", 32'(rdata_valid), 32'h0);
    start = 1'b0;
    $display("txn reset in TW with reserved start pending");

`ifdef Z80_REFRESH_EN
    // 130 back-to-back OCFs: R walks 00..7F and wraps to 00 on the 129th
    start = 1'b1; cyc_type = CYC_OCF_C; addr_in = 16'h0000; ireg_in = 8'h40;
    for (int k = 0; k < 130; k++) begin
      step("ref.t1", V_OCF_A, 16'h0000, T1);
      step("ref.t2", V_OCF_A, 16'h0000, T2);
      step("ref.t3", V_OCF_3, ref_addr(r_exp), T3);
      if (k == 127) chk("ref.addr128", 32'(bus.addr_out), 32'h407F);
      if (k == 128) chk("ref.addr129", 32'(bus.addr_out), 32'h4000);
      step("ref.t4", V_OCF_4, ref_addr(r_exp), T4);
      if (k == 129) start = 1'b0;
      r_exp = (r_exp + 1) % 128;
    end
    step("ref.end", V_IDLE, '0, IDLE);
    $display("txn 130 refresh OCFs, final R=%0d", r_exp);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
